// File: rtl/viterbi_stream_decoder.sv
// viterbi_stream_decoder: streaming soft-input Viterbi decoder.
// Add-compare-select over all trellis states with free-wrapping (modulo)
// path metrics and register-exchange survivors of DEPTH steps.
// Optional feature macro: VITERBI_BEST_STATE_EN selects the sliding-window
// output from the best post-ACS state instead of state 0.
module viterbi_stream_decoder #(
  parameter int STATES    = 8,
  parameter int NOUT      = 2,
  parameter int POLY [NOUT] = '{default: 0},
  parameter int RECURSIVE = 0,
  parameter int SW        = 6,
  parameter int DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NOUT-1:0][SW-1:0]   in_llr,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_data,
  output logic                      out_last
);

  localparam int STATE_BITS = $clog2(STATES);
  localparam int PMW        = SW + $clog2(NOUT) + STATE_BITS + 2;
  localparam int MW         = STATE_BITS + 1;
  localparam int CNTW       = $clog2(DEPTH + 1);
  localparam int IDXW       = $clog2(DEPTH);

  localparam logic [MW-1:0]   REC_MASK = MW'(RECURSIVE);
  localparam logic [PMW-1:0]  PM_FLOOR = {2'b11, {(PMW-2){1'b0}}};
  localparam logic [CNTW-1:0] N_SAT    = CNTW'(DEPTH);

  typedef logic [NOUT-1:0][SW-1:0] llr_t;
  typedef logic [STATE_BITS-1:0]   st_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_LAST
  } state_e;

  // ---------------------------------------------------------------------------
  // Trellis helpers
  // ---------------------------------------------------------------------------
  function automatic logic fb_of(input logic b, input st_t s);
    if (RECURSIVE != 0) return ^({b, s} & REC_MASK);
    return b;
  endfunction

  // Predecessor x (0 = lower index) of next state n.
  function automatic st_t pred_of(input st_t n, input logic x);
    return STATE_BITS'({n, x});
  endfunction

  // Information bit that drives predecessor p into next state n.
  function automatic logic in_bit_of(input st_t n, input st_t p);
    return (fb_of(1'b0, p) == n[STATE_BITS-1]) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [PMW-1:0] branch_metric(input st_t p, input logic b,
                                                   input llr_t llr);
    logic [MW-1:0]  word;
    logic [PMW-1:0] acc;
    logic [PMW-1:0] ext;
    word = {fb_of(b, p), p};
    acc  = '0;
    for (int unsigned j = 0; j < NOUT; j++) begin
      ext = {{(PMW-SW){llr[j][SW-1]}}, llr[j]};
      if (^(word & MW'(POLY[j]))) acc = acc + ext;
      else                        acc = acc - ext;
    end
    return acc;
  endfunction

  // Modulo comparison: a beats b iff (a - b) is strictly positive as signed.
  function automatic logic beats(input logic [PMW-1:0] a, input logic [PMW-1:0] b);
    logic [PMW-1:0] diff;
    diff = a - b;
    return !diff[PMW-1] && (diff != '0);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [CNTW-1:0]     n_q, n_d;
  logic [IDXW-1:0]     fidx_q, fidx_d;
  logic                out_valid_q, out_valid_d;
  logic                out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [PMW-1:0]      pm_q   [STATES];
  logic [PMW-1:0]      pm_d   [STATES];
  logic [DEPTH-1:0]    surv_q [STATES];
  logic [DEPTH-1:0]    surv_d [STATES];

  // ACS results
  st_t                 pred0 [STATES];
  st_t                 pred1 [STATES];
  logic                bit0  [STATES];
  logic                bit1  [STATES];
  logic [PMW-1:0]      cand0 [STATES];
  logic [PMW-1:0]      cand1 [STATES];
  logic                take1 [STATES];
  logic [PMW-1:0]      acs_pm   [STATES];
  logic [DEPTH-1:0]    acs_surv [STATES];
  logic                acs_out  [STATES];
  st_t                 sel_state;

  logic                slot_free;
  logic                accept;
  logic                init_frame;
  logic [CNTW-1:0]     n_inc;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = reset_n && (state_q == S_RUN) && slot_free;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  // Add-compare-select for every next state; ties keep the lower predecessor.
  always_comb begin
    for (int unsigned n = 0; n < STATES; n++) begin
      pred0[n] = pred_of(STATE_BITS'(n), 1'b0);
      pred1[n] = pred_of(STATE_BITS'(n), 1'b1);
      bit0[n]  = in_bit_of(STATE_BITS'(n), pred0[n]);
      bit1[n]  = in_bit_of(STATE_BITS'(n), pred1[n]);
      cand0[n] = pm_q[pred0[n]] + branch_metric(pred0[n], bit0[n], in_llr);
      cand1[n] = pm_q[pred1[n]] + branch_metric(pred1[n], bit1[n], in_llr);
      take1[n] = beats(cand1[n], cand0[n]);
      if (take1[n]) begin
        acs_pm[n]   = cand1[n];
        acs_surv[n] = {surv_q[pred1[n]][DEPTH-2:0], bit1[n]};
        acs_out[n]  = surv_q[pred1[n]][DEPTH-1];
      end else begin
        acs_pm[n]   = cand0[n];
        acs_surv[n] = {surv_q[pred0[n]][DEPTH-2:0], bit0[n]};
        acs_out[n]  = surv_q[pred0[n]][DEPTH-1];
      end
    end
  end

`ifdef VITERBI_BEST_STATE_EN
  // Comparator tree over post-ACS metrics; left (lower-index) subtree wins ties.
  for (genvar l = 0; l <= STATE_BITS; l++) begin : g_lvl
    logic [PMW-1:0] lpm  [STATES >> l];
    st_t            lidx [STATES >> l];
    if (l == 0) begin : g_leaf
      // Leaves are the post-ACS metrics tagged with their own state index.
      always_comb begin
        for (int unsigned k = 0; k < STATES; k++) begin
          lpm[k]  = acs_pm[k];
          lidx[k] = STATE_BITS'(k);
        end
      end
    end else begin : g_node
      // Each node keeps the better of its two children.
      always_comb begin
        for (int unsigned k = 0; k < (STATES >> l); k++) begin
          if (beats(g_lvl[l-1].lpm[2*k+1], g_lvl[l-1].lpm[2*k])) begin
            lpm[k]  = g_lvl[l-1].lpm[2*k+1];
            lidx[k] = g_lvl[l-1].lidx[2*k+1];
          end else begin
            lpm[k]  = g_lvl[l-1].lpm[2*k];
            lidx[k] = g_lvl[l-1].lidx[2*k];
          end
        end
      end
    end
  end
  assign sel_state = g_lvl[STATE_BITS].lidx[0];
`else
  assign sel_state = '0;
`endif

  // Frame control: sliding-window output in RUN, oldest-first drain of state 0 in FLUSH.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    fidx_d      = fidx_q;
    pm_d        = pm_q;
    surv_d      = surv_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    init_frame  = 1'b0;
    n_inc       = (n_q == N_SAT) ? n_q : n_q + 1'b1;
    unique case (state_q)
      S_RUN: begin
        if (accept) begin
          pm_d   = acs_pm;
          surv_d = acs_surv;
          n_d    = n_inc;
          if (n_q == N_SAT) begin
            out_valid_d = 1'b1;
            out_data_d  = acs_out[sel_state];
            out_last_d  = 1'b0;
          end
          if (in_last) begin
            state_d = S_FLUSH;
            fidx_d  = IDXW'(n_inc - 1'b1);
          end
        end
      end
      S_FLUSH: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = surv_q[0][fidx_q];
          out_last_d  = (fidx_q == '0);
          if (fidx_q == '0) begin
            // Survivors are no longer needed once the last bit is registered.
            state_d    = S_LAST;
            init_frame = 1'b1;
          end else begin
            fidx_d = fidx_q - 1'b1;
          end
        end
      end
      S_LAST: begin
        if (out_valid_q && out_ready) begin
          state_d    = S_RUN;
          out_last_d = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase
    if (init_frame) begin
      n_d = '0;
      for (int unsigned k = 0; k < STATES; k++) begin
        pm_d[k]   = (k == 0) ? '0 : PM_FLOOR;
        surv_d[k] = '0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      n_q         <= '0;
      fidx_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_last_q  <= 1'b0;
      for (int unsigned k = 0; k < STATES; k++) begin
        pm_q[k]   <= (k == 0) ? '0 : PM_FLOOR;
        surv_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      fidx_q      <= fidx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      pm_q        <= pm_d;
      surv_q      <= surv_d;
    end
  end

endmodule

// File: tb/tb_viterbi_stream_decoder.sv
// Directed testbench for viterbi_stream_decoder with the (7,5) rate-1/2 code.
module tb_viterbi_stream_decoder;

  localparam int NOUT  = 2;
  localparam int SW    = 6;
  localparam int DEPTH = 32;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [NOUT-1:0][SW-1:0] in_llr;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_data;
  logic                    out_last;

  int errors = 0;
  int checks = 0;

  viterbi_stream_decoder #(
    .STATES    (4),
    .NOUT      (NOUT),
    .POLY      ('{7, 5}),
    .RECURSIVE (0),
    .SW        (SW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_llr    (in_llr),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  logic [SW-1:0] fl0 [$];
  logic [SW-1:0] fl1 [$];
  bit            fexp [$];
  bit            got [$];
  logic [1:0]    enc_s;

  int r_done, r_nlast, r_lastpos, r_bpviol, r_runouts, r_ready_after;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic new_frame();
    fl0.delete();
    fl1.delete();
    fexp.delete();
    enc_s = 2'b00;
  endtask

  // Reference (7,5) encoder: c0 = b^s1^s0, c1 = b^s0; positive LLR means 1.
  task automatic push_step(input bit b, input int mag);
    bit c0, c1;
    c0 = b ^ enc_s[1] ^ enc_s[0];
    c1 = b ^ enc_s[0];
    fl0.push_back(c0 ? SW'(mag) : SW'(-mag));
    fl1.push_back(c1 ? SW'(mag) : SW'(-mag));
    fexp.push_back(b);
    enc_s = {b, enc_s[1]};
  endtask

  task automatic run_frame(input bit throttle, input int abort_at);
    int i, cyc;
    bit done, stop;
    got.delete();
    i = 0; cyc = 0; done = 0; stop = 0;
    r_nlast = 0; r_lastpos = -1; r_bpviol = 0; r_runouts = 0;
    while (!done && !stop && cyc < 5000) begin
      @(negedge clk);
      out_ready = throttle ? (cyc % 3 == 0) : 1'b1;
      in_valid  = (i < fl0.size());
      if (in_valid) begin
        in_llr[0] = fl0[i];
        in_llr[1] = fl1[i];
        in_last   = (i == fl0.size() - 1);
      end else begin
        in_llr  = '0;
        in_last = 1'b0;
      end
      #1;
      if (out_valid && !out_ready && in_ready) r_bpviol++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (i < fl0.size()) r_runouts++;
        if (out_last) begin
          r_nlast++;
          r_lastpos = got.size();
          done = 1;
        end
      end
      if (in_valid && in_ready) i++;
      if (abort_at > 0 && i >= abort_at) stop = 1;
      cyc++;
    end
    r_done = (done || stop) ? 1 : 0;
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    r_ready_after = in_ready;
  endtask

  function automatic int mismatches();
    int m, lim;
    m = 0;
    lim = (got.size() < fexp.size()) ? got.size() : fexp.size();
    for (int k = 0; k < lim; k++) if (got[k] != fexp[k]) m++;
    return m;
  endfunction

  task automatic check_frame(input string tag);
    check({tag, "_timeout"}, r_done, 1);
    check({tag, "_count"}, got.size(), fexp.size());
    check({tag, "_bits"}, mismatches(), 0);
    check({tag, "_nlast"}, r_nlast, 1);
    check({tag, "_lastpos"}, r_lastpos, fexp.size());
    check({tag, "_ready_after"}, r_ready_after, 1);
  endtask

  initial begin
    logic [SW-1:0] keep0 [$];
    logic [SW-1:0] keep1 [$];
    bit            keepx [$];
    logic [7:0]    pat;

    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_llr = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // All-zero frame: 40 data + 2 tail, every llr -20.
    new_frame();
    for (int k = 0; k < 42; k++) push_step(1'b0, 20);
    run_frame(1'b0, 0);
    check_frame("zeros");

    // 100 random data bits + 2 tail steps, noiseless.
    new_frame();
    for (int k = 0; k < 100; k++) push_step(1'($urandom_range(0, 1)), 20);
    push_step(1'b0, 20);
    push_step(1'b0, 20);
    keep0 = fl0; keep1 = fl1; keepx = fexp;
    run_frame(1'b0, 0);
    check_frame("rand");

    // Same frame with one coded bit sign-flipped at reduced magnitude.
    fl0 = keep0; fl1 = keep1; fexp = keepx;
    fl0[50] = fl0[50][SW-1] ? SW'(5) : SW'(-5);
    run_frame(1'b0, 0);
    check_frame("flip");

    // Output back-pressure: out_ready high one cycle in three.
    new_frame();
    for (int k = 0; k < 100; k++) push_step(1'($urandom_range(0, 1)), 20);
    push_step(1'b0, 20);
    push_step(1'b0, 20);
    run_frame(1'b1, 0);
    check_frame("throttle");
    check("throttle_ready_gate", r_bpviol, 0);

    // Short frame (< DEPTH): nothing during RUN, everything in FLUSH.
    new_frame();
    pat = 8'b1011_0010;
    for (int k = 0; k < 8; k++) push_step(pat[7-k], 20);
    push_step(1'b0, 20);
    push_step(1'b0, 20);
    run_frame(1'b0, 0);
    check_frame("short");
    check("short_run_outputs", r_runouts, 0);

    // Single-step frame.
    new_frame();
    push_step(1'b0, 20);
    run_frame(1'b0, 0);
    check_frame("one");

    // Partial frame cut by reset, then a fresh frame.
    new_frame();
    for (int k = 0; k < 30; k++) push_step(1'($urandom_range(0, 1)), 20);
    run_frame(1'b0, 20);
    check("partial_outputs", got.size(), 0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    new_frame();
    for (int k = 0; k < 48; k++) push_step(1'($urandom_range(0, 1)), 20);
    push_step(1'b0, 20);
    push_step(1'b0, 20);
    run_frame(1'b0, 0);
    check_frame("fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/viterbi_stream_decoder.md
# viterbi_stream_decoder

- Streaming soft-input Viterbi decoder for the convolutional codes described by `trellis_if`.
- Inverse of the trellis `Encode` path: takes NOUT soft values per trellis step and emits the decoded information bits in order.
- Uses add-compare-select over all STATES states, modulo path metrics and register-exchange survivors of depth DEPTH.
- Sits after the demapper/LLR quantizer and feeds the frame sink or the turbo outer loop.

## Interface
Parameters:
- STATES, 8, number of trellis states (power of 2); STATE_BITS = $clog2(STATES)
- NOUT, 2, coded bits per step
- POLY, '{default:0}, int[NOUT] generator masks over {input_bit, state}
- RECURSIVE, 0, feedback mask; 0 = feedforward
- SW, 6, soft-value width (signed)
- DEPTH, 32, survivor length in steps (≥ 2)
- PMW = SW + $clog2(NOUT) + STATE_BITS + 2, path-metric width (derived)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  soft step valid
- in_ready  out  1  step accepted when in_valid && in_ready
- in_llr  in  NOUT×SW signed  element j is the soft value for coded bit j; positive means 1
- in_last  in  1  final step of frame (tail steps included)
- out_valid  out  1  decoded bit valid
- out_ready  in  1  sink accepts
- out_data  out  1  decoded information bit
- out_last  out  1  final decoded bit of frame

## Operation
- Trellis:
  - fb = RECURSIVE ? ^({b, s} & RECURSIVE) : b.
  - next = {fb, s[STATE_BITS-1:1]}.
  - Coded bit j = ^({fb, s} & POLY[j]).
  - The decoded bit is b, not fb.
- Branch metric for (s, b) = Σj (coded bit j ? +llr_j : −llr_j), sign-extended to PMW.
- ACS per state:
  - Candidates are the two predecessors, ordered lower state index first.
  - Winner is the larger PM + BM. Comparison is modulo: a beats b iff the signed value (a − b)[PMW-1:0] > 0.
  - On a tie the lower-indexed predecessor wins.
  - PMs wrap freely; no normalization is performed.
- Survivor update: surv[next] = {surv[winner][DEPTH-2:0], b}. The bit shifted out is surv[winner][DEPTH-1].
- FSM states:
  - RUN: accept steps and count n (saturating at DEPTH). For each accepted step with n ≥ DEPTH, emit the shifted-out bit of the selected state (see Configuration). If in_last is accepted, go to FLUSH.
  - FLUSH: in_ready = 0. Emit min(n, DEPTH) bits from surv[0], oldest first. The frame is tail-terminated at state 0. Raise out_last on the final bit. Then reinitialize PMs, survivors and n, and return to RUN.
- Output count always equals input step count. Tail-step bits are emitted and dropped downstream.
- PM initialization at reset and at frame start: PM[0] = 0; all other PMs = −2^(PMW-2). Survivors = 0. n = 0.

## Timing
- Single-entry output register.
  - In RUN, in_ready = !out_valid || out_ready.
  - In RUN, a step accepted at cycle t updates PMs and survivors at t+1. If n ≥ DEPTH, out_valid = 1 at t+1 with that step's decision.
- FLUSH emits at most one bit per cycle, advancing on out_valid && out_ready. out_valid stays high and out_data stable while out_ready = 0.
- in_last accepted at t: FSM is FLUSH at t+1. The first flush bit is presented once any pending RUN output has been taken.
- After the out_last handshake at t, in_ready may be 1 at t+1 (back-to-back frames, no bubble).
- Frame of one step: FLUSH emits exactly 1 bit with out_last = 1.
- Reset values: in_ready = 0 during reset and 1 the cycle after reset; out_valid = 0, out_data = 0, out_last = 0; FSM = RUN.
- reset_n low mid-frame: the partial frame is discarded and no out_last is generated.

## Configuration
- VITERBI_BEST_STATE_EN defined:
  - The sliding-window (RUN) output comes from the state with the highest post-ACS PM.
  - Selection uses a comparator tree with the same modulo comparison; ties go to the lowest index.
  - The tree is combinational within the ACS cycle.
- Undefined:
  - RUN output always comes from state 0's shifted-out bit.
  - Lower area, higher BER for short DEPTH.
- FLUSH always uses state 0 regardless of the macro.

## Test plan
- All-zero frame, 40 data + 2 tail steps, all llr = −20 (STATES=4, POLY='{7,5}) -> 42 zeros, out_last on bit 42.
- Random 100-bit frame encoded by `trellis_if.Encode` with tail_bits=STATE_BITS, llr = ±20 noiseless -> output matches data followed by tail inputs exactly.
- Same frame with one coded bit sign-flipped and set to ±5 -> decoded bits still match exactly.
- out_ready toggling 1-of-3 cycles with in_valid held high -> no lost or duplicated bits, and in_ready = 0 whenever out_valid && !out_ready.
- 10-step frame (< DEPTH) -> no output during RUN, then 10 bits in FLUSH with out_last on the 10th.
- reset_n pulsed low after step 20, then a fresh 50-step frame -> outputs match the fresh frame only, with exactly one out_last.
